pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// Serial "101" pattern scanner: captures a word, shifts it MSB first through an
// overlapping Moore detector and reports the number of matches with valid/ready handshakes.
module pattern_scan_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             chain,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_count,
    input  logic             out_ready,
    output logic             ser_bit,
    output logic [1:0]       PS_out
);

    localparam int unsigned BIT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } det_t;

    state_t           r_state;
    state_t           w_state_next;
    det_t             r_det;
    det_t             w_det_next;
    det_t             w_det_step;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_next;
    logic [BIT_W-1:0] r_bitcnt;
    logic [BIT_W-1:0] w_bitcnt_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic             w_ser;

    assign w_ser     = (r_state == SHIFT) ? r_shift[WIDTH-1] : 1'b0;
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign out_count = r_count;
    assign ser_bit   = w_ser;
    assign PS_out    = r_det;

    // Overlapping detector: after a match a trailing 1 restarts the pattern.
    always_comb begin
        w_det_step = r_det;
        case (r_det)
            S0: w_det_step = w_ser ? S1 : S0;
            S1: w_det_step = w_ser ? S1 : S2;
            S2: w_det_step = w_ser ? S3 : S0;
            S3: w_det_step = w_ser ? S1 : S2;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_det_next    = r_det;
        w_shift_next  = r_shift;
        w_bitcnt_next = r_bitcnt;
        w_count_next  = r_count;
        unique case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_shift_next  = in_data;
                    w_bitcnt_next = '0;
                    w_count_next  = '0;
                    if (!chain) begin
                        w_det_next = S0;
                    end
                    w_state_next = SHIFT;
                end
            end
            SHIFT: begin
                w_det_next    = w_det_step;
                w_shift_next  = {r_shift[WIDTH-2:0], 1'b0};
                w_bitcnt_next = r_bitcnt + BIT_W'(1);
                if (w_det_step == S3 && r_count != {CNT_W{1'b1}}) begin
                    w_count_next = r_count + CNT_W'(1);
                end
                if (r_bitcnt == BIT_W'(WIDTH - 1)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_det    <= S0;
            r_shift  <= '0;
            r_bitcnt <= '0;
            r_count  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_det    <= w_det_next;
            r_shift  <= w_shift_next;
            r_bitcnt <= w_bitcnt_next;
            r_count  <= w_count_next;
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Directed bench for pattern_scan_ctrl: reset abort, single/overlapping matches,
// chaining, back-pressure and back-to-back transfers.
module tb_pattern_scan_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             chain;
    logic             out_valid;
    logic [CNT_W-1:0] out_count;
    logic             out_ready;
    logic             ser_bit;
    logic [1:0]       PS_out;

    int checks = 0;
    int errors = 0;

    int         lat;
    logic [1:0] ps_log [WIDTH];
    logic       ser_log[WIDTH];

    pattern_scan_ctrl #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .chain    (chain),
        .out_valid(out_valid),
        .out_count(out_count),
        .out_ready(out_ready),
        .ser_bit  (ser_bit),
        .PS_out   (PS_out)
    );

    always #5 clk = ~clk;

    // Offers one word, scrambles in_data/chain after acceptance, and records
    // ser_bit/PS_out per shift plus the latency to out_valid (0 = timed out).
    task automatic scan_word(input logic [WIDTH-1:0] data, input logic ch);
        @(negedge clk);
        in_data  = data;
        chain    = ch;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~data;
        chain    = ~ch;
        lat      = 0;
        for (int i = 1; i <= 4 * WIDTH; i++) begin
            if (i <= WIDTH) ser_log[i-1] = ser_bit;
            @(posedge clk);
            #1;
            if (i <= WIDTH) ps_log[i-1] = PS_out;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, PS_out, out_count, ser_bit} !== {1'b1, 1'b0, 2'b00, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b ps=%b cnt=%0d ser=%b, want 1 0 00 0 0",
                     in_ready, out_valid, PS_out, out_count, ser_bit);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        // Word 1010_0000: after three shifts the detector sits in S3 with count 1.
        @(negedge clk);
        in_data  = 8'b1010_0000;
        chain    = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL first_edge_accept: in_ready=%b want 0", in_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (PS_out !== 2'b11 || out_count !== 4'd1) begin
            errors++;
            $display("FAIL pre_abort: ps=%b cnt=%0d want 11 1", PS_out, out_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, PS_out, out_count, ser_bit} !== {1'b0, 1'b1, 2'b00, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL abort_shift: got vld=%b rdy=%b ps=%b cnt=%0d ser=%b, want 0 1 00 0 0",
                     out_valid, in_ready, PS_out, out_count, ser_bit);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (2 * WIDTH) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_result: out_valid seen %0d cycles, want 0", seen);
        end
    endtask

    task automatic test_single();
        scan_word(8'b1010_0000, 1'b0);
        checks++;
        if (lat != WIDTH) begin
            errors++;
            $display("FAIL single_latency: got %0d want %0d", lat, WIDTH);
        end
        checks++;
        if (out_count !== 4'd1) begin
            errors++;
            $display("FAIL single_count: got %0d want 1", out_count);
        end
        checks++;
        if ({ser_log[0], ser_log[1], ser_log[2], ser_log[3]} !== 4'b1010) begin
            errors++;
            $display("FAIL single_ser_bit: got %b%b%b%b want 1010",
                     ser_log[0], ser_log[1], ser_log[2], ser_log[3]);
        end
        checks++;
        if (ser_bit !== 1'b0) begin
            errors++;
            $display("FAIL ser_bit_done: got %b want 0", ser_bit);
        end
        release_result();
    endtask

    task automatic test_overlap();
        logic [1:0] exp_ps[WIDTH];
        exp_ps = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
        scan_word(8'b1010_1010, 1'b0);
        checks++;
        if (lat != WIDTH || out_count !== 4'd3) begin
            errors++;
            $display("FAIL overlap_count: lat=%0d cnt=%0d want %0d 3", lat, out_count, WIDTH);
        end
        for (int i = 0; i < WIDTH; i++) begin
            checks++;
            if (ps_log[i] !== exp_ps[i]) begin
                errors++;
                $display("FAIL overlap_ps[%0d]: got %b want %b", i, ps_log[i], exp_ps[i]);
            end
        end
        release_result();
    endtask

    task automatic test_chain();
        scan_word(8'b0000_0010, 1'b0);
        checks++;
        if (out_count !== 4'd0) begin
            errors++;
            $display("FAIL chain_first: got %0d want 0", out_count);
        end
        release_result();
        scan_word(8'b1000_0000, 1'b1);
        checks++;
        if (out_count !== 4'd1) begin
            errors++;
            $display("FAIL chain_keep: got %0d want 1", out_count);
        end
        release_result();
        scan_word(8'b0000_0010, 1'b0);
        release_result();
        scan_word(8'b1000_0000, 1'b0);
        checks++;
        if (out_count !== 4'd0) begin
            errors++;
            $display("FAIL chain_clear: got %0d want 0", out_count);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        // 1011_0101 ends in S3 with three matches.
        scan_word(8'b1011_0101, 1'b0);
        checks++;
        if (lat != WIDTH || out_count !== 4'd3) begin
            errors++;
            $display("FAIL bp_result: lat=%0d cnt=%0d want %0d 3", lat, out_count, WIDTH);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'b1010_0000;
            chain    = 1'b0;
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, in_ready, out_count, PS_out} !== {1'b1, 1'b0, 4'd3, 2'b11}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got vld=%b rdy=%b cnt=%0d ps=%b want 1 0 3 11",
                         i, out_valid, in_ready, out_count, PS_out);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || PS_out !== 2'b11) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b ps=%b want 0 1 11",
                     out_valid, in_ready, PS_out);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        out_ready = 1'b1;
        in_data   = 8'b1010_0000;
        chain     = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        // Hold in_valid with the next word; it must be ignored until IDLE returns.
        in_data = 8'b1010_1010;
        repeat (WIDTH) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, in_ready, out_count} !== {1'b1, 1'b0, 4'd1}) begin
            errors++;
            $display("FAIL b2b_first: got vld=%b rdy=%b cnt=%0d want 1 0 1",
                     out_valid, in_ready, out_count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_one_cycle: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept2: in_ready=%b want 0", in_ready);
        end
        repeat (WIDTH) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_count !== 4'd3) begin
            errors++;
            $display("FAIL b2b_second: got vld=%b cnt=%0d want 1 3", out_valid, out_count);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_end: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        chain     = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_overlap();
        test_chain();
        test_backpressure();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
